// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared constants and the sequencer state encoding for the
//               pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Register-file address width of the five-stage core
    localparam int REG_ADDR_W = 4;

    // Default width of the stall/flush performance counters
    localparam int DEF_CNT_W  = 16;

    // Sequencer states: RUN lets the pipe flow, MEM_WAIT holds it for SRAM
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Bundle of pipeline status inputs and control outputs between
//               the datapath (master) and the hazard controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    // ID-stage sources
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  use_src1;
    logic                  two_src;
    // EXE/MEM-stage destinations and memory activity
    logic                  exe_wb_en;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  exe_mem_r_en;
    logic                  mem_wb_en;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  mem_ready;
    // Global modifiers
    logic                  forward_en;
    logic                  branch_taken;
    logic                  cnt_clr;
    // Pipeline controls and status
    logic                  mem_start;
    logic                  freeze_if;
    logic                  flush_if;
    logic                  flush_id;
    logic                  freeze_pipe;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic                  mem_timeout;

    modport master (
        output src1, src2, use_src1, two_src,
        output exe_wb_en, exe_dest, exe_mem_r_en,
        output mem_wb_en, mem_dest, mem_r_en, mem_w_en, mem_ready,
        output forward_en, branch_taken, cnt_clr,
        input  mem_start, freeze_if, flush_if, flush_id, freeze_pipe,
        input  stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  src1, src2, use_src1, two_src,
        input  exe_wb_en, exe_dest, exe_mem_r_en,
        input  mem_wb_en, mem_dest, mem_r_en, mem_w_en, mem_ready,
        input  forward_en, branch_taken, cnt_clr,
        output mem_start, freeze_if, flush_if, flush_id, freeze_pipe,
        output stall_cnt, flush_cnt, mem_timeout
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational RAW hazard detection between the ID sources
//               and the EXE/MEM destinations. With forwarding active only a
//               load in EXE (load-use) can still cause a hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  wire logic [REG_ADDR_W-1:0] i_src1,
    input  wire logic [REG_ADDR_W-1:0] i_src2,
    input  wire logic                  i_use_src1,
    input  wire logic                  i_two_src,
    input  wire logic                  i_exe_wb_en,
    input  wire logic [REG_ADDR_W-1:0] i_exe_dest,
    input  wire logic                  i_exe_mem_r_en,
    input  wire logic                  i_mem_wb_en,
    input  wire logic [REG_ADDR_W-1:0] i_mem_dest,
    input  wire logic                  i_forward_en,
    output logic                       o_hazard
);

    logic w_exe_vld;
    logic w_mem_vld;
    logic w_src1_hit;
    logic w_src2_hit;

    // Forwarding covers every producer except a load still in EXE
    assign w_exe_vld  = i_exe_wb_en & (~i_forward_en | i_exe_mem_r_en);
    assign w_mem_vld  = i_mem_wb_en & ~i_forward_en;

    assign w_src1_hit = (w_exe_vld & (i_src1 == i_exe_dest)) |
                        (w_mem_vld & (i_src1 == i_mem_dest));
    assign w_src2_hit = (w_exe_vld & (i_src2 == i_exe_dest)) |
                        (w_mem_vld & (i_src2 == i_mem_dest));

    assign o_hazard   = (i_use_src1 & w_src1_hit) | (i_two_src & w_src2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Pipeline sequencer. Decides load/hold/clear of the pipeline
//               registers from RAW hazards, taken branches and SRAM accesses,
//               and keeps saturating stall/flush counters plus a sticky
//               memory-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_WAIT = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int               WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] C_WAIT_TO  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_mem_op;
    logic w_hazard;
    logic w_mem_start;
    logic w_freeze_pipe;
    logic w_freeze_if;
    logic w_flush_if;
    logic w_flush_id;

    assign w_mem_op = bus.mem_r_en | bus.mem_w_en;

    hazard_detect u_hazard_detect (
        .i_src1         (bus.src1),
        .i_src2         (bus.src2),
        .i_use_src1     (bus.use_src1),
        .i_two_src      (bus.two_src),
        .i_exe_wb_en    (bus.exe_wb_en),
        .i_exe_dest     (bus.exe_dest),
        .i_exe_mem_r_en (bus.exe_mem_r_en),
        .i_mem_wb_en    (bus.mem_wb_en),
        .i_mem_dest     (bus.mem_dest),
        .i_forward_en   (bus.forward_en),
        .o_hazard       (w_hazard)
    );

    // Pipeline controls: memory freeze dominates, then branch flush, then
    // hazard stall; everything is held low while reset is asserted
    always_comb begin
        w_mem_start   = 1'b0;
        w_freeze_pipe = 1'b0;
        w_freeze_if   = 1'b0;
        w_flush_if    = 1'b0;
        w_flush_id    = 1'b0;
        if (rst) begin
            if (r_state == ST_RUN) begin
                w_mem_start   = w_mem_op;
                w_freeze_pipe = w_mem_op;
            end else begin
                w_freeze_pipe = ~bus.mem_ready;
            end
            // Branch/hazard are re-evaluated after the freeze since EXE is held
            if (!w_freeze_pipe) begin
                if (bus.branch_taken) begin
                    w_flush_if = 1'b1;
                    w_flush_id = 1'b1;
                end else if (w_hazard) begin
                    w_freeze_if = 1'b1;
                    w_flush_id  = 1'b1;
                end
            end
        end
    end

    // Memory-access sequencer with saturating wait counter and sticky timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_op) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt != C_WAIT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        // Flag as the counter reaches MAX_WAIT; keep waiting
                        if (r_wait_cnt == C_WAIT_TO) begin
                            r_mem_timeout <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_freeze_if | w_freeze_pipe) && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_if && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.mem_start   = w_mem_start;
    assign bus.freeze_pipe = w_freeze_pipe;
    assign bus.freeze_if   = w_freeze_if;
    assign bus.flush_if    = w_flush_if;
    assign bus.flush_id    = w_flush_id;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
    assign bus.mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: directed
//               scenarios followed by random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int TB_CNT_W    = 4;
    localparam int TB_MAX_WAIT = 6;
    localparam int TB_CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .CNT_W    (TB_CNT_W),
        .MAX_WAIT (TB_MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: in_wait flag, ready-low cycles of current access,
    // sticky timeout and the two counters as plain integers
    bit m_wait;
    int m_low;
    bit m_to;
    int m_stall;
    int m_flush;
    bit e_ms, e_fp, e_fi, e_fif, e_fid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit depends_on(input logic [REG_ADDR_W-1:0] s);
        bit from_exe, from_mem;
        from_exe = bus.exe_wb_en && (s == bus.exe_dest) &&
                   (!bus.forward_en || bus.exe_mem_r_en);
        from_mem = !bus.forward_en && bus.mem_wb_en && (s == bus.mem_dest);
        return from_exe || from_mem;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_low = 0; m_to = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic clear_inputs();
        bus.src1 = '0; bus.src2 = '0; bus.use_src1 = 0; bus.two_src = 0;
        bus.exe_wb_en = 0; bus.exe_dest = '0; bus.exe_mem_r_en = 0;
        bus.mem_wb_en = 0; bus.mem_dest = '0; bus.mem_r_en = 0; bus.mem_w_en = 0;
        bus.mem_ready = 0; bus.forward_en = 0; bus.branch_taken = 0; bus.cnt_clr = 0;
    endtask

    // Let inputs settle, predict this cycle's controls and compare everything
    task automatic settle();
        bit mop, hz;
        #3;
        mop = bus.mem_r_en || bus.mem_w_en;
        hz  = (bus.use_src1 && depends_on(bus.src1)) || (bus.two_src && depends_on(bus.src2));
        e_ms = !m_wait && mop;
        e_fp = m_wait ? !bus.mem_ready : mop;
        e_fi = 0; e_fif = 0; e_fid = 0;
        if (!e_fp) begin
            if (bus.branch_taken) begin
                e_fif = 1; e_fid = 1;
            end else if (hz) begin
                e_fi = 1; e_fid = 1;
            end
        end
        check("mem_start",   32'(bus.mem_start),   32'(e_ms));
        check("freeze_pipe", 32'(bus.freeze_pipe), 32'(e_fp));
        check("freeze_if",   32'(bus.freeze_if),   32'(e_fi));
        check("flush_if",    32'(bus.flush_if),    32'(e_fif));
        check("flush_id",    32'(bus.flush_id),    32'(e_fid));
        check("stall_cnt",   32'(bus.stall_cnt),   32'(m_stall));
        check("flush_cnt",   32'(bus.flush_cnt),   32'(m_flush));
        check("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
    endtask

    // Advance one clock and apply the same cycle to the model
    task automatic tick();
        bit mop;
        mop = bus.mem_r_en || bus.mem_w_en;
        @(posedge clk);
        if (bus.cnt_clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if ((e_fi || e_fp) && m_stall < TB_CNT_MAX) m_stall++;
            if (e_fif && m_flush < TB_CNT_MAX) m_flush++;
        end
        if (!m_wait) begin
            if (mop) begin
                m_wait = 1; m_low = 0;
            end
        end else if (bus.mem_ready) begin
            m_wait = 0;
        end else begin
            m_low++;
            if (m_low >= TB_MAX_WAIT) m_to = 1;
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic set_raw_hazard();
        bus.src1 = 4'd3; bus.use_src1 = 1; bus.exe_wb_en = 1; bus.exe_dest = 4'd3;
    endtask

    initial begin
        // Reset with active hazard/branch/mem inputs: controls must stay low
        clear_inputs();
        model_reset();
        set_raw_hazard();
        bus.branch_taken = 1;
        bus.mem_r_en = 1;
        #2;
        check("rst_mem_start",   32'(bus.mem_start),   32'd0);
        check("rst_freeze_pipe", 32'(bus.freeze_pipe), 32'd0);
        check("rst_flush_if",    32'(bus.flush_if),    32'd0);
        check("rst_stall_cnt",   32'(bus.stall_cnt),   32'd0);
        #10 rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;

        // RAW hazard without forwarding
        set_raw_hazard();
        settle();
        check("nofwd_freeze_if", 32'(bus.freeze_if), 32'd1);
        check("nofwd_flush_id",  32'(bus.flush_id),  32'd1);
        tick();
        check("nofwd_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Forwarding: plain ALU producer is not a hazard, a load is
        bus.forward_en = 1;
        settle();
        check("fwd_alu_freeze_if", 32'(bus.freeze_if), 32'd0);
        tick();
        bus.exe_mem_r_en = 1;
        settle();
        check("fwd_load_freeze_if", 32'(bus.freeze_if), 32'd1);
        check("fwd_load_flush_id",  32'(bus.flush_id),  32'd1);
        tick();

        // Branch beats hazard
        bus.cnt_clr = 1; step(); bus.cnt_clr = 0;
        bus.branch_taken = 1;
        settle();
        check("br_flush_if",  32'(bus.flush_if),  32'd1);
        check("br_freeze_if", 32'(bus.freeze_if), 32'd0);
        tick();
        check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);

        // Load with three ready-low wait cycles
        clear_inputs();
        bus.cnt_clr = 1; step(); bus.cnt_clr = 0;
        bus.mem_r_en = 1;
        settle();
        check("ld_mem_start", 32'(bus.mem_start), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ld_wait_freeze", 32'(bus.freeze_pipe), 32'd1);
            check("ld_wait_start",  32'(bus.mem_start),   32'd0);
            tick();
        end
        bus.mem_ready = 1;
        settle();
        check("ld_ready_freeze", 32'(bus.freeze_pipe), 32'd0);
        tick();
        check("ld_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        clear_inputs();
        step();

        // Timeout: sticky across ready and counter clear
        bus.mem_w_en = 1;
        step();
        for (int i = 0; i < TB_MAX_WAIT + 2; i++) begin
            if (i == TB_MAX_WAIT - 1) check("to_not_yet", 32'(bus.mem_timeout), 32'd0);
            step();
        end
        check("to_set", 32'(bus.mem_timeout), 32'd1);
        bus.mem_ready = 1;
        step();
        clear_inputs();
        bus.cnt_clr = 1;
        step();
        bus.cnt_clr = 0;
        check("to_after_clr", 32'(bus.mem_timeout), 32'd1);

        // Asynchronous reset in the middle of a wait
        bus.mem_r_en = 1; step();
        bus.mem_r_en = 0; step();
        bus.branch_taken = 1;
        #2 rst = 1'b0;
        #1;
        check("arst_freeze_pipe", 32'(bus.freeze_pipe), 32'd0);
        check("arst_flush_if",    32'(bus.flush_if),    32'd0);
        check("arst_timeout",     32'(bus.mem_timeout), 32'd0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        settle();
        check("arst_no_start", 32'(bus.mem_start), 32'd0);
        tick();

        // Stall counter saturation over 20 hazard cycles
        set_raw_hazard();
        for (int i = 0; i < 20; i++) step();
        check("stall_sat", 32'(bus.stall_cnt), 32'(TB_CNT_MAX));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.src1         = 4'($urandom_range(0, 3));
            bus.src2         = 4'($urandom_range(0, 3));
            bus.use_src1     = 1'($urandom);
            bus.two_src      = 1'($urandom);
            bus.exe_wb_en    = 1'($urandom);
            bus.exe_dest     = 4'($urandom_range(0, 3));
            bus.exe_mem_r_en = 1'($urandom);
            bus.mem_wb_en    = 1'($urandom);
            bus.mem_dest     = 4'($urandom_range(0, 3));
            bus.mem_r_en     = ($urandom_range(0, 7) == 0);
            bus.mem_w_en     = ($urandom_range(0, 15) == 0);
            bus.mem_ready    = ($urandom_range(0, 2) == 0);
            bus.forward_en   = 1'($urandom);
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.cnt_clr      = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central pipeline sequencer for the five-stage ARM core. Every cycle it decides whether the IF/ID/EXE/MEM pipeline registers load, hold, or clear. It detects RAW hazards between the instruction in ID and the destinations in EXE/MEM, with or without forwarding. It squashes wrong-path instructions on a taken branch, and it stalls the whole pipe while the external SRAM controller completes a memory access. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- REG_ADDR_W, 4, register-file address width
- CNT_W, 16, performance counter width
- MAX_WAIT, 64, MEM_WAIT cycles before mem_timeout sets

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- src1  in  REG_ADDR_W  Rn of instruction in ID
- src2  in  REG_ADDR_W  Rm/Rd-store source of instruction in ID
- use_src1  in  1  ID instruction reads src1
- two_src  in  1  ID instruction reads src2
- exe_wb_en  in  1  EXE-stage instruction writes back
- exe_dest  in  REG_ADDR_W  EXE-stage destination
- exe_mem_r_en  in  1  EXE-stage instruction is a load
- mem_wb_en  in  1  MEM-stage instruction writes back
- mem_dest  in  REG_ADDR_W  MEM-stage destination
- mem_r_en, mem_w_en  in  1 each  MEM-stage load/store
- mem_ready  in  1  SRAM controller done, valid only in MEM_WAIT
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE resolved a taken branch
- cnt_clr  in  1  synchronous clear of performance counters
- mem_start  out  1  one-cycle pulse launching SRAM access
- freeze_if  out  1  hold PC and IF/ID register
- flush_if  out  1  clear IF/ID register
- flush_id  out  1  clear ID/EXE register (insert bubble)
- freeze_pipe  out  1  hold IF, ID, EXE, MEM registers and PC
- stall_cnt  out  CNT_W  cycles with freeze_if or freeze_pipe
- flush_cnt  out  CNT_W  taken-branch flushes
- mem_timeout  out  1  sticky, wait exceeded MAX_WAIT

## Operation
- FSM states: RUN, MEM_WAIT. Reset state RUN.
- mem_op = mem_r_en | mem_w_en.
- RUN with mem_op:
  - mem_start=1 and freeze_pipe=1.
  - Next state MEM_WAIT; wait_cnt cleared.
- MEM_WAIT:
  - freeze_pipe = !mem_ready.
  - On mem_ready go to RUN; the pipe advances in that same cycle.
  - Otherwise wait_cnt++ (saturating).
  - When wait_cnt reaches MAX_WAIT, mem_timeout sets. The FSM keeps waiting and does not abort.
- mem_start is never asserted in MEM_WAIT.
- hazard with forward_en=0: (use_src1 & src1 match) | (two_src & src2 match). "Match" means equal to exe_dest with exe_wb_en, or equal to mem_dest with mem_wb_en.
- hazard with forward_en=1: the same source terms, but only against exe_dest with exe_wb_en & exe_mem_r_en (load-use only).
- Priority when freeze_pipe=0:
  1. branch_taken: flush_if=flush_id=1, freeze_if=0.
  2. hazard: freeze_if=1, flush_id=1.
  3. Otherwise all controls 0.
- When freeze_pipe=1: freeze_if, flush_if and flush_id are all 0. A branch or hazard is re-evaluated once the pipe resumes, because the EXE contents are held.
- stall_cnt increments on any cycle with freeze_if|freeze_pipe.
- flush_cnt increments on any cycle with flush_if.
- Both counters saturate at all-ones.
- cnt_clr zeroes both counters and takes precedence over increment. mem_timeout is not affected.

## Timing
- Hazard, branch and freeze outputs are combinational from the inputs and the state, with zero latency.
- Minimum memory access is 2 cycles: RUN (mem_start, freeze), then MEM_WAIT with mem_ready=1.
- A wait of N ready-low cycles costs N+2 cycles in total.
- rst low, asynchronous:
  - state=RUN; wait_cnt, stall_cnt and flush_cnt=0; mem_timeout=0.
  - All combinational outputs are forced to 0 while rst is low.
- Reset asserted mid-MEM_WAIT: the FSM returns to RUN immediately. No mem_start pulse occurs until the first cycle after release in which mem_op=1.

## Structure
- Shared constants package holds:
  - REG_ADDR_W
  - the state encoding (RUN=0, MEM_WAIT=1)
  - the counter width
- One sub-module: hazard_detect, a combinational block computing hazard from the sources, destinations and forward_en.
- The FSM, counters and priority logic are kept at the top level.

## Test plan
- forward_en=0, src1=3, use_src1=1, exe_wb_en=1, exe_dest=3 -> freeze_if=1, flush_id=1, stall_cnt +1.
- forward_en=1, same operands, exe_mem_r_en=0 -> no hazard. With exe_mem_r_en=1 -> freeze_if=1, flush_id=1.
- branch_taken=1 together with a hazard -> flush_if=flush_id=1, freeze_if=0, flush_cnt=1.
- mem_r_en=1, mem_ready low for 3 cycles, then high:
  - mem_start pulses once.
  - freeze_pipe is high for 4 cycles, then low.
  - FSM returns to RUN and stall_cnt=4.
- mem_ready held low for MAX_WAIT+2 cycles -> mem_timeout=1, stays 1 after ready and after cnt_clr. Cleared only by rst.
- rst pulsed low mid-MEM_WAIT -> all outputs 0 asynchronously. After release with mem_op=0: state RUN, no mem_start. stall_cnt saturation checked with CNT_W=4 over 20 stall cycles -> 15.
